// File: rtl/ads1672_pkg.sv
// Shared definitions for the ADS1672 serial-port emulator and the host-side reader.
package ads1672_pkg;

    localparam int ADS1672_DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        READY,
        SHIFT
    } ads1672_emu_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall pulses on the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // One flop beyond the synchronizer chain holds the previous level for edge detection.
    logic [STAGES:0] sync_q;
    logic [STAGES:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-1:0], din};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~sync_q[STAGES];
    assign fall  = ~sync_q[STAGES-1] & sync_q[STAGES];

endmodule

// File: rtl/ads1672_adc_emu.sv
// ADS1672 serial output port emulator: paces conversions, raises drdy_n and shifts samples out MSB first.
module ads1672_adc_emu
    import ads1672_pkg::*;
#(
    parameter int DATA_WIDTH  = ADS1672_DATA_WIDTH,
    parameter int DRDY_PERIOD = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sclk,
    input  logic                  fs,
    output logic                  drdy_n,
    output logic                  dout,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  stale,
    output logic                  overrun
);

    localparam int CW = $clog2(DRDY_PERIOD);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DRDY_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH);

    logic start_lvl, start_rise, start_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic fs_lvl, fs_rise, fs_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk(clk), .rst(rst), .din(start), .level(start_lvl), .rise(start_rise), .fall(start_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_fs (
        .clk(clk), .rst(rst), .din(fs), .level(fs_lvl), .rise(fs_rise), .fall(fs_fall)
    );

    assign unused_edges = ^{start_rise, start_fall, sclk_lvl, fs_lvl, fs_fall};

    ads1672_emu_state_t    state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic                  drdy_n_q, drdy_n_d;
    logic                  dout_q, dout_d;
    logic                  rearm_q, rearm_d;

    logic                  tick;
    logic                  done;
    logic [BW-1:0]         bit_inc;
    logic [DATA_WIDTH-1:0] word;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        last_d       = last_q;
        drdy_n_d     = drdy_n_q;
        dout_d       = dout_q;
        rearm_d      = rearm_q;
        sample_ready = 1'b0;
        stale        = 1'b0;
        overrun      = 1'b0;

        tick    = (state_q != IDLE) && (cnt_q == '0);
        bit_inc = bit_q + 1'b1;
        done    = (state_q == SHIFT) && sclk_fall && (bit_inc == BIT_LAST);
        word    = sample_valid ? sample_data : last_q;

        if (!start_lvl) begin
            state_d  = IDLE;
            cnt_d    = '0;
            bit_d    = '0;
            drdy_n_d = 1'b1;
            dout_d   = 1'b0;
            rearm_d  = 1'b0;
        end else begin
            if (state_q != IDLE) begin
                cnt_d = tick ? CNT_RELOAD : cnt_q - 1'b1;
            end
            if (tick) begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    last_d = sample_data;
                end else begin
                    stale = 1'b1;
                end
            end

            unique case (state_q)
                IDLE: begin
                    state_d = CONVERT;
                    cnt_d   = CNT_RELOAD;
                end
                CONVERT: begin
                    if (tick) begin
                        shreg_d  = word;
                        bit_d    = '0;
                        drdy_n_d = 1'b0;
                        dout_d   = word[DATA_WIDTH-1];
                        state_d  = READY;
                    end
                end
                READY: begin
                    // rearm_q marks the single drdy_n-high clock after a reload mid-read.
                    if (rearm_q) begin
                        drdy_n_d = 1'b0;
                        dout_d   = shreg_q[DATA_WIDTH-1];
                        rearm_d  = 1'b0;
                    end else if (sclk_fall) begin
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        bit_d   = bit_inc;
                        state_d = SHIFT;
                    end else if (fs_rise) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        bit_d   = bit_inc;
                        if (done) begin
                            drdy_n_d = 1'b1;
                            dout_d   = 1'b0;
                            state_d  = CONVERT;
                        end
                    end else if (sclk_rise) begin
                        dout_d = shreg_q[DATA_WIDTH-1];
                    end
                end
                default: state_d = IDLE;
            endcase

            // A tick while a word is still presented reloads it; a coincident final bit is not an overrun.
            if (tick && (state_q == READY || state_q == SHIFT)) begin
                shreg_d  = word;
                bit_d    = '0;
                drdy_n_d = 1'b1;
                state_d  = READY;
                rearm_d  = 1'b1;
                if (done) begin
                    dout_d = 1'b0;
                end else begin
                    overrun = 1'b1;
                    dout_d  = word[DATA_WIDTH-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            last_q   <= '0;
            drdy_n_q <= 1'b1;
            dout_q   <= 1'b0;
            rearm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            last_q   <= last_d;
            drdy_n_q <= drdy_n_d;
            dout_q   <= dout_d;
            rearm_q  <= rearm_d;
        end
    end

    assign drdy_n = drdy_n_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_ads1672_adc_emu.sv
// Self-checking bench for ads1672_adc_emu, acting as the host reader against a word-level model.
module tb_ads1672_adc_emu;
    import ads1672_pkg::*;

    localparam int DW   = ADS1672_DATA_WIDTH;
    localparam int DRDY = 256;
    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          sclk = 1'b0;
    logic          fs = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic          drdy_n, dout, sample_ready, stale, overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int sr_cnt = 0, st_cnt = 0, ov_cnt = 0;
    int fall_cnt = 0, last_fall_cyc = 0, hi_run = 0, last_hi_run = 0;
    logic drdy_prev = 1'b1;
    logic [DW-1:0] model_last = '0;

    ads1672_adc_emu #(
        .DATA_WIDTH(DW),
        .DRDY_PERIOD(DRDY),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sclk(sclk), .fs(fs),
        .drdy_n(drdy_n), .dout(dout),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .stale(stale), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample_ready === 1'b1) sr_cnt <= sr_cnt + 1;
        if (stale === 1'b1)        st_cnt <= st_cnt + 1;
        if (overrun === 1'b1)      ov_cnt <= ov_cnt + 1;
        if (drdy_prev === 1'b1 && drdy_n === 1'b0) begin
            fall_cnt      <= fall_cnt + 1;
            last_fall_cyc <= cyc;
            last_hi_run   <= hi_run;
        end
        hi_run    <= (drdy_n === 1'b1) ? hi_run + 1 : 0;
        drdy_prev <= drdy_n;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Model: the word presented after a tick is the new sample if valid, else the last one held.
    task automatic set_sample(input logic [DW-1:0] d, input logic v, output logic [DW-1:0] exp_w);
        exp_w        = v ? d : model_last;
        model_last   = exp_w;
        sample_data  = d;
        sample_valid = v;
    endtask

    task automatic wait_fall();
        int n0;
        n0 = fall_cnt;
        for (int i = 0; i < 3 * DRDY && fall_cnt == n0; i++) @(negedge clk);
        n_cmp++;
        if (fall_cnt == n0) begin
            n_err++;
            $display("FAIL drdy_fall_timeout: got no fall, required a fall within %0d clk", 3 * DRDY);
        end
    endtask

    task automatic read_word(input logic use_fs, input logic [DW-1:0] exp_w, input string tag);
        logic [DW-1:0] w;
        int k;
        w = '0;
        if (use_fs) begin
            fs = 1'b1;
            repeat (HALF) @(negedge clk);
            fs = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        for (int b = 0; b < DW; b++) begin
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            w = {w[DW-2:0], dout};
            sclk = 1'b0;
            if (b == DW - 1) begin
                k = 0;
                while (drdy_n !== 1'b1 && k < SYNC + 2) begin
                    @(negedge clk);
                    k++;
                end
                n_cmp++;
                if (drdy_n !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s_drdy_release: drdy_n=%b, required 1 after last falling edge", tag, drdy_n);
                end
            end
            repeat (HALF) @(negedge clk);
        end
        n_cmp++;
        if (w !== exp_w) begin
            n_err++;
            $display("FAIL %s_word: got %h, required %h", tag, w, exp_w);
        end
    endtask

    task automatic test_reset();
        int s0, t0, o0;
        rst = 1'b0;
        start = 1'b1;
        s0 = sr_cnt; t0 = st_cnt; o0 = ov_cnt;
        for (int i = 0; i < 5; i++) begin
            sclk = ~sclk;
            @(negedge clk);
            n_cmp++;
            if ({drdy_n, dout, sample_ready, stale, overrun} !== 5'b10000) begin
                n_err++;
                $display("FAIL reset_outputs: got drdy_n/dout/rdy/stale/ovr=%b, required 10000",
                         {drdy_n, dout, sample_ready, stale, overrun});
            end
        end
        start = 1'b0;
        sclk = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (sr_cnt != s0 || st_cnt != t0 || ov_cnt != o0) begin
            n_err++;
            $display("FAIL reset_pulses: got %0d pulses, required 0", (sr_cnt - s0) + (st_cnt - t0) + (ov_cnt - o0));
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] e;
        int c0, s0;
        set_sample(24'hA5F00F, 1'b1, e);
        s0 = sr_cnt;
        start = 1'b1;
        c0 = cyc;
        wait_fall();
        n_cmp++;
        if (last_fall_cyc - c0 != SYNC + DRDY + 1) begin
            n_err++;
            $display("FAIL single_latency: got %0d clk, required %0d", last_fall_cyc - c0, SYNC + DRDY + 1);
        end
        n_cmp++;
        if (sr_cnt - s0 != 1) begin
            n_err++;
            $display("FAIL single_ready: got %0d sample_ready pulses, required 1", sr_cnt - s0);
        end
        read_word(1'b1, 24'hA5F00F, "single");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e1, e2;
        int f0, f1, s0, t0, o0;
        f0 = last_fall_cyc;
        s0 = sr_cnt; t0 = st_cnt; o0 = ov_cnt;
        set_sample(24'h800000, 1'b1, e1);
        wait_fall();
        f1 = last_fall_cyc;
        set_sample(24'h7FFFFF, 1'b1, e2);
        read_word(1'b1, e1, "b2b_first");
        wait_fall();
        n_cmp++;
        if (f1 - f0 != DRDY || last_fall_cyc - f1 != DRDY) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d and %0d clk, required %0d", f1 - f0, last_fall_cyc - f1, DRDY);
        end
        read_word(1'b1, e2, "b2b_second");
        n_cmp++;
        if (sr_cnt - s0 != 2 || st_cnt != t0 || ov_cnt != o0) begin
            n_err++;
            $display("FAIL b2b_pulses: got ready/stale/ovr %0d/%0d/%0d, required 2/0/0",
                     sr_cnt - s0, st_cnt - t0, ov_cnt - o0);
        end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] e;
        logic [31:0] r;
        int o0;
        r = $urandom();
        set_sample(r[DW-1:0], 1'b1, e);
        wait_fall();
        set_sample(24'h000001, 1'b1, e);
        o0 = ov_cnt;
        wait_fall();
        n_cmp++;
        if (ov_cnt - o0 != 1) begin
            n_err++;
            $display("FAIL overrun_pulse: got %0d pulses, required 1", ov_cnt - o0);
        end
        n_cmp++;
        if (last_hi_run != 1) begin
            n_err++;
            $display("FAIL overrun_drdy_gap: got drdy_n high %0d clk, required 1", last_hi_run);
        end
        read_word(1'b1, 24'h000001, "overrun");
    endtask

    task automatic test_stale();
        logic [DW-1:0] e1, e2;
        int t0;
        set_sample(24'h123456, 1'b1, e1);
        wait_fall();
        set_sample(24'hDEAD00, 1'b0, e2);
        read_word(1'b1, 24'h123456, "stale_first");
        t0 = st_cnt;
        wait_fall();
        n_cmp++;
        if (st_cnt - t0 != 1) begin
            n_err++;
            $display("FAIL stale_pulse: got %0d pulses, required 1", st_cnt - t0);
        end
        read_word(1'b0, 24'h123456, "stale_repeat");
    endtask

    task automatic test_abort();
        logic [DW-1:0] e;
        logic [31:0] r;
        int c0, s0;
        r = $urandom();
        set_sample(r[DW-1:0], 1'b1, e);
        wait_fall();
        fs = 1'b1;
        repeat (HALF) @(negedge clk);
        fs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        s0 = sr_cnt;
        start = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        n_cmp++;
        if (drdy_n !== 1'b1 || dout !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got drdy_n=%b dout=%b, required 1 0", drdy_n, dout);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (drdy_n !== 1'b1 || sr_cnt != s0) begin
            n_err++;
            $display("FAIL abort_quiet: got drdy_n=%b ready pulses=%0d, required 1 0", drdy_n, sr_cnt - s0);
        end
        r = $urandom();
        set_sample(r[DW-1:0], 1'b1, e);
        start = 1'b1;
        c0 = cyc;
        wait_fall();
        n_cmp++;
        if (last_fall_cyc - c0 != SYNC + DRDY + 1) begin
            n_err++;
            $display("FAIL restart_latency: got %0d clk, required %0d", last_fall_cyc - c0, SYNC + DRDY + 1);
        end
        read_word(1'b1, e, "restart");
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        logic [31:0] r;
        logic v;
        int f0, t0;
        for (int it = 0; it < 6; it++) begin
            r = $urandom();
            v = ($urandom_range(0, 3) != 0);
            set_sample(r[DW-1:0], v, e);
            f0 = last_fall_cyc;
            t0 = st_cnt;
            wait_fall();
            n_cmp++;
            if (last_fall_cyc - f0 != DRDY || st_cnt - t0 != (v ? 0 : 1)) begin
                n_err++;
                $display("FAIL random_period: iter %0d got %0d clk stale=%0d, required %0d clk stale=%0d",
                         it, last_fall_cyc - f0, st_cnt - t0, DRDY, v ? 0 : 1);
            end
            read_word(($urandom_range(0, 1) == 1), e, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_stale();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
